mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_MAX, default 32'h0000ffff, is the highest legal word address; any address above it is out of range.
REQ-002 clk  input  1  clock; all state changes on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 iReq  input  1  fetch requester: read request, held until iAck.
REQ-005 iAddr  input  32  fetch address, stable while iReq is high.
REQ-006 iAck  output  1  one-cycle pulse: fetch complete.
REQ-007 iErr  output  1  qualifies iAck: fetch rejected.
REQ-008 iData  output  32  fetched word, valid while iAck is high and held until the next fetch ack.
REQ-009 dReq  input  1  data requester: request, held until dAck.
REQ-010 dWe  input  1  data request is a write (1) or a read (0).
REQ-011 dAddr  input  32  data address.
REQ-012 dWdata  input  32  store data.
REQ-013 dAck  output  1  one-cycle pulse: data access complete.
REQ-014 dErr  output  1  qualifies dAck: data access rejected.
REQ-015 dRdata  output  32  load word, valid with dAck.
REQ-016 mAddr  output  32  memory address.
REQ-017 mIn  output  32  memory write data.
REQ-018 mRead  output  1  memory read enable.
REQ-019 mWrite  output  1  memory write enable; the memory writes on the posedge of clk.
REQ-020 mOut  input  32  memory read data, combinational from mAddr.

Function
REQ-021 The FSM SHALL have three states: IDLE, BUSY_I and BUSY_D.
REQ-022 In IDLE, on a posedge with an eligible request, the FSM SHALL latch the address, the write data and dWe, then enter BUSY_I or BUSY_D.
REQ-023 A requester SHALL be ineligible in any cycle in which its own ack is high, so that a request still held during its ack is not re-granted.
REQ-024 In BUSY_x, mAddr, mIn, mRead and mWrite SHALL be driven from the latched values; outside BUSY_x, mRead and mWrite SHALL be 0 and mAddr and mIn SHALL hold their last values.
REQ-025 On the posedge that leaves BUSY_x, mOut SHALL be registered into iData or dRdata (reads only), the matching ack SHALL be set for one cycle, and the FSM SHALL return to IDLE.
REQ-026 Latency from a request sampled in IDLE to its ack SHALL be exactly 2 cycles.
REQ-027 A write SHALL occur at the posedge that ends BUSY_D, and dRdata SHALL be unchanged by a write.
REQ-028 If the latched address has addr[1:0] != 0 or is greater than ADDR_MAX, the arbiter SHALL keep mRead=0 and mWrite=0 in BUSY_x and SHALL assert ack together with err; the read data register SHALL be unchanged.
REQ-029 iErr and dErr SHALL be 0 whenever their ack is 0.
REQ-030 When both requests are eligible in IDLE with the default policy, the data requester SHALL win and the fetch requester SHALL wait.
REQ-031 A single eligible request SHALL always be granted, regardless of policy.
REQ-032 Requests that rise during BUSY SHALL be sampled only when the FSM is back in IDLE.

Reset
REQ-033 rst SHALL immediately force: state IDLE; iAck, dAck, iErr, dErr, mRead and mWrite to 0; iData, dRdata, mAddr and mIn to 0; the round-robin pointer to "data last".
REQ-034 An access in flight when rst asserts SHALL be abandoned: no ack is issued and no memory write occurs.

Configuration
REQ-035 With MEM_ARB_RR_EN defined, a conflict in IDLE SHALL grant the requester not granted most recently, and the pointer SHALL update on every grant.
REQ-036 With MEM_ARB_RR_EN undefined, the fixed data-over-fetch priority of REQ-030 SHALL apply and no pointer register SHALL exist.

Structure
REQ-037 Package mem_arb_pkg SHALL hold the state encoding (IDLE, BUSY_I, BUSY_D), the default ADDR_MAX, and the word-alignment and range check function.
REQ-038 Sub-module mem_arb_pick SHALL contain the combinational grant selection (fixed priority or round robin), taking the eligible requests and the pointer as inputs.

Verification
REQ-039 Fetch read: iReq=1 with iAddr=32'h28 and memory word 28 = 32'h8c0a0000 -> iAck pulses 2 cycles later with iData=32'h8c0a0000 and iErr=0; no second grant while iReq drops.
REQ-040 Store then load: dWe=1, dAddr=32'h100, dWdata=32'hdeadbeef, then dWe=0 at the same address -> the read returns 32'hdeadbeef, mWrite was high for exactly one cycle, and dRdata was unchanged by the store.
REQ-041 Conflict: iReq and dReq rise in the same cycle -> default build gives dAck at cycle 2 and iAck at cycle 4; the MEM_ARB_RR_EN build with pointer "data last" gives iAck first.
REQ-042 Errors: dAddr=32'h102 read and iAddr=32'h10000 -> each ack arrives with err=1, mRead and mWrite stay 0, and the data registers are unchanged.
REQ-043 Reset mid-write: rst asserted during BUSY_D with dWe=1 -> mWrite drops immediately, the memory word is unchanged, no dAck, and the FSM is in IDLE.
REQ-044 Back-to-back fetch: iReq held across its ack, then renewed -> a new grant occurs only after the ack cycle, giving one access per 3 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types, widths and the address legality check for the memory arbiter.
package mem_arb_pkg;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [AW-1:0] ADDR_MAX_DEFAULT = 32'h0000_ffff;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  // Word-aligned and not above the highest legal word address.
  function automatic logic addr_ok(input logic [AW-1:0] addr, input logic [AW-1:0] max);
    return (addr[1:0] == 2'b00) && (addr <= max);
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Fetch, data and memory-side signals of the arbiter; slave = arbiter, master = environment.
interface mem_arb_if;
  import mem_arb_pkg::*;

  logic          iReq;
  logic [AW-1:0] iAddr;
  logic          iAck;
  logic          iErr;
  logic [DW-1:0] iData;

  logic          dReq;
  logic          dWe;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] dWdata;
  logic          dAck;
  logic          dErr;
  logic [DW-1:0] dRdata;

  logic [AW-1:0] mAddr;
  logic [DW-1:0] mIn;
  logic          mRead;
  logic          mWrite;
  logic [DW-1:0] mOut;

  modport slave (
    input  iReq, iAddr, dReq, dWe, dAddr, dWdata, mOut,
    output iAck, iErr, iData, dAck, dErr, dRdata, mAddr, mIn, mRead, mWrite
  );

  modport master (
    output iReq, iAddr, dReq, dWe, dAddr, dWdata, mOut,
    input  iAck, iErr, iData, dAck, dErr, dRdata, mAddr, mIn, mRead, mWrite
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection; round robin when MEM_ARB_RR_EN is defined, else data over fetch.
module mem_arb_pick (
  input  logic i_elig_i,
  input  logic d_elig_i,
  input  logic last_d_i,
  output logic gnt_i_c_o,
  output logic gnt_d_c_o
);

`ifdef MEM_ARB_RR_EN
  // On conflict the requester not served most recently wins.
  always_comb begin
    gnt_d_c_o = d_elig_i & (~i_elig_i | ~last_d_i);
    gnt_i_c_o = i_elig_i & (~d_elig_i | last_d_i);
  end
`else
  logic unused_last_d;
  assign unused_last_d = last_d_i;

  always_comb begin
    gnt_d_c_o = d_elig_i;
    gnt_i_c_o = i_elig_i & ~d_elig_i;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter with registered memory strobes.
// Optional round-robin arbitration via MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [AW-1:0] ADDR_MAX = ADDR_MAX_DEFAULT
) (
  input logic        clk,
  input logic        rst,
  mem_arb_if.slave   bus
);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic          bad_q, bad_d;
  logic          iack_q, iack_d, ierr_q, ierr_d;
  logic          dack_q, dack_d, derr_q, derr_d;
  logic          mread_q, mread_d, mwrite_q, mwrite_d;
  logic [DW-1:0] idata_q, idata_d, drdata_q, drdata_d, min_q, min_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic          i_elig, d_elig, gnt_i, gnt_d, last_d;
  logic          ok_i, ok_d;

  // A request is not re-granted in its own ack cycle.
  assign i_elig = bus.iReq & ~iack_q;
  assign d_elig = bus.dReq & ~dack_q;
  assign ok_i   = addr_ok(bus.iAddr, ADDR_MAX);
  assign ok_d   = addr_ok(bus.dAddr, ADDR_MAX);

`ifdef MEM_ARB_RR_EN
  logic last_d_q, last_d_d;
  assign last_d = last_d_q;

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE) begin
      if (gnt_d)      last_d_d = 1'b1;
      else if (gnt_i) last_d_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_d_q <= 1'b1;
    else     last_d_q <= last_d_d;
  end
`else
  assign last_d = 1'b1;
`endif

  mem_arb_pick u_pick (
    .i_elig_i  (i_elig),
    .d_elig_i  (d_elig),
    .last_d_i  (last_d),
    .gnt_i_c_o (gnt_i),
    .gnt_d_c_o (gnt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_d)      state_d = BUSY_D;
        else if (gnt_i) state_d = BUSY_I;
      end
      BUSY_I, BUSY_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes are high only for the BUSY cycle.
  always_comb begin
    we_d     = we_q;
    bad_d    = bad_q;
    maddr_d  = maddr_q;
    min_d    = min_q;
    idata_d  = idata_q;
    drdata_d = drdata_q;
    mread_d  = 1'b0;
    mwrite_d = 1'b0;
    iack_d   = 1'b0;
    ierr_d   = 1'b0;
    dack_d   = 1'b0;
    derr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_d) begin
          maddr_d  = bus.dAddr;
          min_d    = bus.dWdata;
          we_d     = bus.dWe;
          bad_d    = ~ok_d;
          mread_d  = ok_d & ~bus.dWe;
          mwrite_d = ok_d & bus.dWe;
        end else if (gnt_i) begin
          maddr_d  = bus.iAddr;
          we_d     = 1'b0;
          bad_d    = ~ok_i;
          mread_d  = ok_i;
        end
      end
      BUSY_I: begin
        iack_d = 1'b1;
        ierr_d = bad_q;
        if (!bad_q) idata_d = bus.mOut;
      end
      BUSY_D: begin
        dack_d = 1'b1;
        derr_d = bad_q;
        if (!bad_q && !we_q) drdata_d = bus.mOut;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      bad_q    <= 1'b0;
      maddr_q  <= '0;
      min_q    <= '0;
      idata_q  <= '0;
      drdata_q <= '0;
      mread_q  <= 1'b0;
      mwrite_q <= 1'b0;
      iack_q   <= 1'b0;
      ierr_q   <= 1'b0;
      dack_q   <= 1'b0;
      derr_q   <= 1'b0;
    end else begin
      we_q     <= we_d;
      bad_q    <= bad_d;
      maddr_q  <= maddr_d;
      min_q    <= min_d;
      idata_q  <= idata_d;
      drdata_q <= drdata_d;
      mread_q  <= mread_d;
      mwrite_q <= mwrite_d;
      iack_q   <= iack_d;
      ierr_q   <= ierr_d;
      dack_q   <= dack_d;
      derr_q   <= derr_d;
    end
  end

  assign bus.iAck   = iack_q;
  assign bus.iErr   = ierr_q;
  assign bus.iData  = idata_q;
  assign bus.dAck   = dack_q;
  assign bus.dErr   = derr_q;
  assign bus.dRdata = drdata_q;
  assign bus.mAddr  = maddr_q;
  assign bus.mIn    = min_q;
  assign bus.mRead  = mread_q;
  assign bus.mWrite = mwrite_q;

endmodule
